// File: rtl/game_pkg.sv
// game_pkg: button indices, button count and repeat-FSM states shared by the input path.
package game_pkg;
  localparam int NUM_BTNS   = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTRE = 4;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce one raw button, with registered press/release pulses.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   w_match;
  logic                   w_flip;
  assign w_match = r_sync[SYNC_STAGES-1] == o_level;
  assign w_flip  = !w_match && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt     <= (w_match || w_flip) ? '0 : r_cnt + 1'b1;
      o_level   <= o_level ^ w_flip;
      o_press   <= w_flip && !o_level;
      o_release <= w_flip && o_level;
    end
  end
endmodule

// File: rtl/btn_move_conditioner.sv
// btn_move_conditioner: debounced buttons plus a rate-limited, auto-repeating move strobe.
module btn_move_conditioner
  import game_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 1666667
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                move_strobe,
  output logic [3:0]          move_dir
);
  localparam int TMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    w_ud;
  logic [1:0]    w_lr;
  logic [3:0]    w_dir;
  logic          w_press;
  logic          w_fire;
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw[i]),
      .o_level  (btn_level[i]),
      .o_press  (btn_press[i]),
      .o_release(btn_release[i])
    );
  end
  // Opposing pairs held together cancel to no motion on that axis.
  assign w_ud    = &btn_level[BTN_DOWN:BTN_UP] ? 2'b00 : btn_level[BTN_DOWN:BTN_UP];
  assign w_lr    = &btn_level[BTN_RIGHT:BTN_LEFT] ? 2'b00 : btn_level[BTN_RIGHT:BTN_LEFT];
  assign w_dir   = {w_lr, w_ud};
  assign w_press = |btn_press[BTN_RIGHT:BTN_UP];
  assign w_fire  = w_dir != 4'b0 && (w_press || (r_state != IDLE && r_timer == '0));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      move_strobe <= 1'b0;
      move_dir    <= 4'b0;
    end else begin
      move_strobe <= w_fire;
      move_dir    <= w_fire ? w_dir : 4'b0;
      if (w_dir == 4'b0 || (r_state == IDLE && !w_press)) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else if (w_press) begin
        r_state <= DELAY;
        r_timer <= TW'(REPEAT_DELAY - 1);
      end else if (r_timer == '0) begin
        r_state <= REPEAT;
        r_timer <= TW'(REPEAT_RATE - 1);
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btn_move_conditioner.sv
// tb_btn_move_conditioner: directed cycle-exact checks of debounce, press/release and move strobes.
module tb_btn_move_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = 5'b0;
  logic [4:0] btn_level, btn_press, btn_release;
  logic       move_strobe;
  logic [3:0] move_dir;
  int checks = 0;
  int errors = 0;
  int s;
  logic [4:0] acc;
  logic exp_s;
  btn_move_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .move_strobe(move_strobe),
    .move_dir   (move_dir)
  );
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_count(int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      cnt += int'(move_strobe);
    end
  endtask
  initial begin
    btn_raw = 5'b11111;
    tick();
    chk("rst_outs_1", 32'({btn_level, btn_press, btn_release, move_strobe, move_dir}), 0);
    tick(2);
    chk("rst_outs_3", 32'({btn_level, btn_press, btn_release, move_strobe, move_dir}), 0);
    rst = 1'b0;
    tick(5);
    chk("rst_lvl_early", 32'(btn_level), 0);
    tick();
    chk("rst_lvl", 32'(btn_level), 32'h1f);
    chk("rst_press", 32'(btn_press), 32'h1f);
    chk("rst_dir", 32'(move_dir), 0);
    tick();
    chk("rst_nostrobe", 32'(move_strobe), 0);
    chk("rst_press_off", 32'(btn_press), 0);
    btn_raw = 5'b0;
    tick(5);
    chk("rel_all_early", 32'(btn_level), 32'h1f);
    tick();
    chk("rel_all_lvl", 32'(btn_level), 0);
    chk("rel_all_pulse", 32'(btn_release), 32'h1f);
    tick();
    chk("rel_all_pulse_off", 32'(btn_release), 0);
    chk("rel_all_nostrobe", 32'(move_strobe), 0);
    acc = 5'b0;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (2) begin
        tick();
        acc |= btn_level | btn_press;
        s += int'(move_strobe);
      end
    end
    repeat (6) begin
      tick();
      acc |= btn_level | btn_press;
      s += int'(move_strobe);
    end
    chk("bounce_lvl_press", 32'(acc), 0);
    chk("bounce_strobe", 32'(s), 0);
    btn_raw[0] = 1'b1;
    tick(5);
    chk("tap_lvl_early", 32'(btn_level), 0);
    tick();
    chk("tap_lvl", 32'(btn_level), 32'h01);
    chk("tap_press", 32'(btn_press), 32'h01);
    chk("tap_no_same_cycle_strobe", 32'(move_strobe), 0);
    tick();
    chk("tap_strobe", 32'(move_strobe), 1);
    chk("tap_dir", 32'(move_dir), 32'h1);
    tick();
    chk("tap_strobe_single", 32'(move_strobe), 0);
    chk("tap_dir_zero", 32'(move_dir), 0);
    btn_raw[0] = 1'b0;
    run_count(5, s);
    chk("tap_hold_nostrobe", 32'(s), 0);
    chk("tap_lvl_before_fall", 32'(btn_level), 32'h01);
    tick();
    chk("tap_lvl_fall", 32'(btn_level), 0);
    chk("tap_release", 32'(btn_release), 32'h01);
    run_count(12, s);
    chk("tap_idle_nostrobe", 32'(s), 0);
    btn_raw[3] = 1'b1;
    tick(6);
    chk("rep_press", 32'(btn_press), 32'h08);
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_s = k == 1 || k == 11 || k == 14 || k == 17;
      chk($sformatf("rep_strobe_p%0d", k), 32'(move_strobe), 32'(exp_s));
      chk($sformatf("rep_dir_p%0d", k), 32'(move_dir), exp_s ? 32'h8 : 0);
    end
    btn_raw[3] = 1'b0;
    tick(6);
    chk("rep_rel_lvl", 32'(btn_level), 0);
    run_count(8, s);
    chk("rep_stopped", 32'(s), 0);
    btn_raw[0] = 1'b1;
    tick(6);
    chk("dc_up_press", 32'(btn_press), 32'h01);
    tick(14);
    chk("dc_up_repeat_strobe", 32'(move_strobe), 1);
    chk("dc_up_repeat_dir", 32'(move_dir), 32'h1);
    btn_raw[2] = 1'b1;
    tick(6);
    chk("dc_left_press", 32'(btn_press), 32'h04);
    tick();
    chk("dc_left_strobe", 32'(move_strobe), 1);
    chk("dc_left_dir", 32'(move_dir), 32'h5);
    for (int k = 2; k <= 11; k++) begin
      tick();
      exp_s = k == 11;
      chk($sformatf("dc_delay_strobe_p%0d", k), 32'(move_strobe), 32'(exp_s));
      chk($sformatf("dc_delay_dir_p%0d", k), 32'(move_dir), exp_s ? 32'h5 : 0);
    end
    btn_raw[1] = 1'b1;
    tick(6);
    chk("dc_down_press", 32'(btn_press), 32'h02);
    tick();
    chk("dc_down_strobe", 32'(move_strobe), 1);
    chk("dc_down_dir", 32'(move_dir), 32'h4);
    btn_raw = 5'b0;
    tick(12);
    chk("centre_pre_lvl", 32'(btn_level), 0);
    btn_raw[4] = 1'b1;
    tick(6);
    chk("centre_press", 32'(btn_press), 32'h10);
    run_count(4, s);
    chk("centre_nostrobe", 32'(s), 0);
    chk("centre_press_once", 32'(btn_press), 0);
    btn_raw[4] = 1'b0;
    tick(8);
    btn_raw[3] = 1'b1;
    tick(6);
    chk("rr_press", 32'(btn_press), 32'h08);
    tick(11);
    chk("rr_first_repeat", 32'(move_strobe), 1);
    tick(2);
    rst = 1'b1;
    tick();
    chk("rr_outs_zero", 32'({btn_level, btn_press, btn_release, move_strobe, move_dir}), 0);
    btn_raw = 5'b0;
    tick();
    rst = 1'b0;
    run_count(10, s);
    chk("rr_no_strobe_after", 32'(s), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_move_conditioner.md
Name: btn_move_conditioner

Overview:
- Producer side of the button-to-motion interface used by the game logic.
- Takes the five raw, asynchronous, bouncy board buttons and synchronises and debounces them. It emits clean levels, press/release pulses, and a rate-limited, auto-repeating move strobe with a direction vector.
- Runs in the 100 MHz board clock domain and replaces ad-hoc divided clocks: consumers update position only on the single-cycle move_strobe.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 1000000: consecutive cycles of changed input required before a level flips (10 ms at 100 MHz).
- REPEAT_DELAY, 25000000: cycles from the first move strobe to the first auto-repeat strobe (250 ms).
- REPEAT_RATE, 1666667: cycles between auto-repeat strobes (about 60 Hz).

Ports:
- clk  in  1  board clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  5  raw buttons {centre,right,left,down,up}; asynchronous.
- btn_level  out  5  debounced levels, same bit order.
- btn_press  out  5  one-cycle pulse on each debounced 0->1 transition.
- btn_release  out  5  one-cycle pulse on each debounced 1->0 transition.
- move_strobe  out  1  one-cycle pulse: the consumer applies one step.
- move_dir  out  4  {right,left,down,up}, after opposing-pair cancellation; valid while move_strobe=1, otherwise 0.

Behaviour:
- Reset: all synchroniser flops, counters, btn_level, btn_press, btn_release, move_strobe and move_dir are 0; the FSM is IDLE. Reset applied mid-debounce or mid-repeat aborts the operation, with no strobe on the following cycle.
- Synchroniser: SYNC_STAGES flops per bit; the last stage is sync[i].
- Debounce, per bit:
  - The counter clears whenever sync[i]==btn_level[i].
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the input is still mismatched, btn_level[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
  - Latency from a stable raw edge to btn_level is exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - btn_press/btn_release are registered and asserted in the same cycle the level changes.
- Effective direction: dir_eff = dir levels with up&down both set cleared to 0 for that pair, and left&right likewise.
- Repeat FSM (directions only; centre is excluded):
  - IDLE: on any btn_press[3:0] with dir_eff!=0, go to DELAY. One cycle after that press, move_strobe=1 and move_dir=dir_eff. Load the timer with REPEAT_DELAY-1.
  - DELAY: the timer decrements. At 0, strobe with the current dir_eff, load REPEAT_RATE-1, and go to REPEAT.
  - REPEAT: the timer decrements. At 0, strobe and reload REPEAT_RATE-1.
  - DELAY/REPEAT: a new btn_press[3:0] strobes immediately (next cycle), reloads REPEAT_DELAY-1, and returns to DELAY.
  - DELAY/REPEAT: if dir_eff becomes 0 (all released, or only an opposing pair held), go to IDLE. No strobe is issued; the timer is discarded.
  - When a timer expiry and a new press occur in the same cycle, only one strobe is issued and the press rule wins (reload REPEAT_DELAY-1).
- move_strobe never asserts on two consecutive cycles except through back-to-back presses on different buttons.
- Counter widths are $clog2(param+1); no counter wraps in normal operation.

Decomposition:
- Shared package game_pkg holds:
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_CENTRE=4;
  - NUM_BTNS=5;
  - the FSM state enum {IDLE, DELAY, REPEAT}.
- Sub-module btn_debounce: synchroniser, counter, level and press/release for one bit, instantiated NUM_BTNS times.
- The repeat FSM stays in the top module.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset/idle: hold rst 3 cycles with btn_raw=5'b11111 -> all outputs 0 during reset. After release, btn_level=11111 at cycle 6, with btn_press=11111 for 1 cycle and move_dir=0 (both pairs cancel, no strobe).
- Bounce: toggle up every 2 cycles for 20 cycles, then hold low -> btn_level[0] stays 0 and there is no press or strobe. Hold high -> level rises exactly 6 cycles after the last edge.
- Single tap: up held 8 cycles after level rise, then released -> exactly one move_strobe with move_dir=4'b0001, one cycle after btn_press[0]. btn_release[0] fires 6 cycles after the raw fall.
- Auto-repeat: hold right -> first strobe at P+1 (P = press cycle), then at P+11, P+14, P+17 with move_dir=4'b1000. Release -> strobes stop, FSM IDLE.
- Direction change: hold up into REPEAT, then press left -> a strobe with 4'b0101 the cycle after left's press, next strobe 10 cycles later. Then press down -> dir_eff=4'b0100 (up/down cancel), with a strobe issued.
- Centre: press centre alone -> btn_press[4] pulses once, move_strobe stays 0. Assert rst during REPEAT -> no further strobe, all outputs 0 the next cycle.
